// File: rtl/sp_ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_fifo_ctrl_if
//  Description : Stream and single-port RAM signals of the FIFO controller.
//                The slave modport is the controller. The master modport is
//                the surrounding logic: the producer, the consumer and the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sp_ram_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  // push stream
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  // pop stream
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  // occupancy
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  // single-port RAM
  logic [DATA_WIDTH-1:0] ram_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  in_valid, in_data, out_ready, ram_q,
    output in_ready, out_valid, out_data, count, full, empty,
           ram_data, ram_addr, ram_we
  );

  modport master (
    output in_valid, in_data, out_ready, ram_q,
    input  in_ready, out_valid, out_data, count, full, empty,
           ram_data, ram_addr, ram_we
  );
endinterface
`default_nettype wire

// File: rtl/sp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sp_ram_fifo_ctrl
//  Description : FIFO controller that uses a single-port RAM as its storage
//                array. Each cycle the RAM port serves one access, and reads
//                win. A one-word output register holds the head word.
//  Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                clk,
  input  logic                rst,
  sp_ram_fifo_ctrl_if.slave   bus
);

  localparam logic [ADDR_WIDTH-1:0] c_PTR_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_rd_pend;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_rd_go;
  logic                  w_wr_go;
  logic                  w_in_ready;
  logic [ADDR_WIDTH:0]   w_count;

  // Port arbitration. A read is issued only when the output register will be
  // free by the time q arrives. A read also blocks a push in the same cycle.
  always_comb begin
    w_rd_go    = !rst && (r_ram_cnt != '0) && !r_rd_pend &&
                 (!r_out_valid || bus.out_ready);
    w_in_ready = !rst && (r_ram_cnt != c_DEPTH) && !w_rd_go;
    w_wr_go    = bus.in_valid && w_in_ready;
  end

  // Pointer and RAM occupancy bookkeeping. The pointers wrap at DEPTH-1, so
  // DEPTH does not have to be a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
    end else begin
      if (w_wr_go) begin
        r_wr_ptr  <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
        r_ram_cnt <= r_ram_cnt + 1'b1;
      end else if (w_rd_go) begin
        r_rd_ptr  <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
        r_ram_cnt <= r_ram_cnt - 1'b1;
      end
    end
  end

  // Read pipeline. rd_pend marks the cycle where q carries the requested word,
  // and that word is captured into the output register on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pend   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_rd_pend <= w_rd_go;
      if (r_rd_pend) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.ram_q;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Total words held in the block: words in the RAM, plus the word being
  // read, plus the word in the output register.
  always_comb begin
    w_count = r_ram_cnt + (ADDR_WIDTH + 1)'(r_rd_pend) +
              (ADDR_WIDTH + 1)'(r_out_valid);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.count     = w_count;
  assign bus.full      = (r_ram_cnt == c_DEPTH);
  assign bus.empty     = (w_count == '0);
  assign bus.ram_addr  = w_rd_go ? r_rd_ptr : r_wr_ptr;
  assign bus.ram_we    = w_wr_go;
  assign bus.ram_data  = bus.in_data;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sp_ram_fifo_ctrl
//  Description : Scoreboard bench for sp_ram_fifo_ctrl. It contains a
//                behavioural model of the single-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_ram_fifo_ctrl;

  localparam int c_AW    = 6;
  localparam int c_DW    = 8;
  localparam int c_DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sp_ram_fifo_ctrl_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) bus ();

  sp_ram_fifo_ctrl #(
    .ADDR_WIDTH (c_AW),
    .DATA_WIDTH (c_DW),
    .DEPTH      (c_DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM with a registered, read-first q.
  logic [c_DW-1:0] mem [c_DEPTH];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard. Words are queued when the push handshake completes. Each
  // word is checked when it leaves the pop side.
  logic [c_DW-1:0] sb[$];
  int              m_wptr   = 0;
  int              n_popped = 0;
  logic [c_DW-1:0] last_pop = '0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      m_wptr = 0;
    end else begin
      chk("count_vs_model", 32'(bus.count), 32'(sb.size()));
      chk("count_max", 32'(bus.count <= 7'(c_DEPTH + 1)), 32'd1);
      chk("we_eq_push", 32'(bus.ram_we), 32'(bus.in_valid && bus.in_ready));
      if (bus.ram_we) begin
        chk("wr_addr", 32'(bus.ram_addr), 32'(m_wptr));
        m_wptr = (m_wptr == c_DEPTH - 1) ? 0 : m_wptr + 1;
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
      if (bus.out_valid && bus.out_ready) begin
        n_popped++;
        last_pop = bus.out_data;
        if (sb.size() == 0) chk("pop_underflow", 32'd1, 32'd0);
        else                chk("pop_data", 32'(bus.out_data), 32'(sb.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Offer one word and hold it until it is accepted. Returns just after the
  // edge that accepted the word.
  task automatic push(input logic [c_DW-1:0] d);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      step();
      if (acc) break;
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (bus.empty) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("drain_empty", 32'(done), 32'd1);
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int base;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    do_reset();

    // Idle state after reset, then the latency of a single push
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_empty",     32'(bus.empty),     32'd1);
    chk("rst_full",      32'(bus.full),      32'd0);
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_ram_we",    32'(bus.ram_we),    32'd0);
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    @(negedge clk);
    chk("lat_n_we",   32'(bus.ram_we),   32'd1);
    chk("lat_n_addr", 32'(bus.ram_addr), 32'd0);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_n1_we",    32'(bus.ram_we),   32'd0);
    chk("lat_n1_raddr", 32'(bus.ram_addr), 32'd0);
    chk("lat_n1_rdy",   32'(bus.in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("lat_n2_ovalid", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("lat_n3_ovalid", 32'(bus.out_valid), 32'd1);
    chk("lat_n3_odata",  32'(bus.out_data),  32'h01);
    step();
    drain();

    // Three back-to-back pushes, then drain them in order
    do_reset();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    drain();

    // Fill the FIFO: 64 words in the RAM and 1 in the output register
    do_reset();
    for (int i = 0; i < c_DEPTH + 1; i++) push(8'(i + 8'h40));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    @(negedge clk);
    chk("full_flag",     32'(bus.full),     32'd1);
    chk("full_count",    32'(bus.count),    32'd65);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_no_we",    32'(bus.ram_we),   32'd0);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("full_release", 32'(bus.full), 32'd0);
    step();
    drain();

    // Push and pop in the same cycle: the read takes the RAM port
    do_reset();
    push(8'h10);
    push(8'h11);
    repeat (4) step();
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h12;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("coll_we",    32'(bus.ram_we),   32'd0);
    chk("coll_addr",  32'(bus.ram_addr), 32'd1);
    chk("coll_ready", 32'(bus.in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("coll_next_ready", 32'(bus.in_ready), 32'd1);
    chk("coll_next_addr",  32'(bus.ram_addr), 32'd2);
    step();
    bus.in_valid = 1'b0;
    drain();

    // Random stream of 200 words. The pointers wrap several times.
    do_reset();
    base = n_popped;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) step();
          push(8'(i));
        end
      end
      begin
        for (int t = 0; t < 20000 && (n_popped - base) < 200; t++) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          step();
        end
        bus.out_ready = 1'b0;
      end
    join
    chk("stream_popped", 32'(n_popped - base), 32'd200);
    drain();

    // Reset while a read is in flight
    do_reset();
    for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
    repeat (4) step();
    @(negedge clk);
    chk("pre_rst_count", 32'(bus.count), 32'd6);
    step();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("inflight_count", 32'(bus.count), 32'd5);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_count",  32'(bus.count),     32'd0);
    chk("mid_rst_ovalid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_empty",  32'(bus.empty),     32'd1);
    step();
    base = n_popped;
    bus.out_ready = 1'b1;
    push(8'hAA);
    for (int t = 0; t < 20 && n_popped == base; t++) step();
    chk("after_rst_popcnt", 32'(n_popped - base), 32'd1);
    chk("after_rst_first",  32'(last_pop),        32'hAA);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
